// File: rtl/weight_fetch_sequencer.sv
// weight_fetch_sequencer: walks a layer's weight memory (1-cycle read latency) and streams tagged weights over valid/ready.
// Define WFETCH_BIAS_EN to append a bias word (input index NUM_INPUTS) to every neuron.
module weight_fetch_sequencer #(
    parameter int NUM_INPUTS  = 5,
    parameter int NUM_NEURONS = 1,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [IDX_WIDTH-1:0]  w_input_idx,
    output logic [IDX_WIDTH-1:0]  w_neuron_idx,
    output logic                  w_last_input,
    output logic                  w_last_neuron
);
`ifdef WFETCH_BIAS_EN
    localparam int WORDS_PER_NEURON = NUM_INPUTS + 1;
`else
    localparam int WORDS_PER_NEURON = NUM_INPUTS;
`endif
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [IDX_WIDTH-1:0] input_idx;
        logic [IDX_WIDTH-1:0] neuron_idx;
        logic                 last_input;
        logic                 last_neuron;
    } tag_t;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        tag_t                  tag;
    } word_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [IDX_WIDTH-1:0]  in_cnt, nrn_cnt;
    logic                  last_in, last_nrn, last_word, pop, inflight;
    logic [1:0]            count;
    logic [2:0]            occupancy;
    tag_t                  side;
    word_t                 fifo [2];

    assign last_in   = in_cnt == IDX_WIDTH'(WORDS_PER_NEURON - 1);
    assign last_nrn  = nrn_cnt == IDX_WIDTH'(NUM_NEURONS - 1);
    assign last_word = last_in && last_nrn;
    assign pop       = w_valid && w_ready;
    // Buffer slots still committed after this edge: stored + landing - leaving.
    assign occupancy = 3'(count) + 3'(inflight) - 3'(pop);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next      = state;
        busy            = state == FETCH || state == DRAIN;
        done            = state == DONE;
        mem_read_enable = 1'b0;
        case (state)
            IDLE:  state_next = start && !abort ? FETCH : IDLE;
            FETCH: begin
                mem_read_enable = !abort && occupancy < 3'd2;
                state_next      = abort ? IDLE : mem_read_enable && last_word ? DRAIN : FETCH;
            end
            DRAIN: state_next = abort ? IDLE : occupancy == 3'd0 ? DONE : DRAIN;
            DONE:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr     <= '0;
            in_cnt   <= '0;
            nrn_cnt  <= '0;
            inflight <= 1'b0;
            side     <= '0;
            count    <= '0;
            fifo[0]  <= '0;
            fifo[1]  <= '0;
        end else begin
            if (state == IDLE && start && !abort) begin
                addr    <= base_addr;
                in_cnt  <= '0;
                nrn_cnt <= '0;
            end
            if (mem_read_enable) begin
                addr    <= addr + ADDR_WIDTH'(1);
                in_cnt  <= last_in ? '0 : in_cnt + IDX_WIDTH'(1);
                nrn_cnt <= last_in ? nrn_cnt + IDX_WIDTH'(1) : nrn_cnt;
                side    <= '{in_cnt, nrn_cnt, last_in, last_nrn};
            end
            if (abort && busy) begin
                inflight <= 1'b0;
                count    <= '0;
            end else begin
                inflight <= mem_read_enable;
                count    <= count + 2'(inflight) - 2'(pop);
                if (pop)
                    fifo[0] <= fifo[1];
                if (inflight)
                    fifo[1'(count - 2'(pop))] <= '{mem_read_data, side};
            end
        end
    end

    assign w_valid       = count != 2'd0;
    assign mem_read_addr = addr;
    assign {w_data, w_input_idx, w_neuron_idx, w_last_input, w_last_neuron} = fifo[0];

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// tb_weight_fetch_sequencer: randomized runs of weight_fetch_sequencer checked against an index-arithmetic model.
module tb_weight_fetch_sequencer;
    localparam int NI = 5, NN = 2, AW = 10, DW = 16, IW = 8;
`ifdef WFETCH_BIAS_EN
    localparam int WPN = NI + 1;
`else
    localparam int WPN = NI;
`endif
    localparam int TOTAL = WPN * NN;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, w_ready;
    logic [AW-1:0] base_addr, mem_read_addr;
    logic [DW-1:0] mem_read_data, w_data;
    logic          busy, done, mem_read_enable, w_valid, w_last_input, w_last_neuron;
    logic [IW-1:0] w_input_idx, w_neuron_idx;

    int checks = 0, errors = 0;
    int run_base, rd_cnt, out_cnt, last_acc, cyc;
    logic          prev_v, prev_r;
    logic [DW-1:0] prev_d;

    weight_fetch_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .ADDR_WIDTH(AW),
                             .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
        .busy(busy), .done(done), .mem_read_enable(mem_read_enable), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_input_idx(w_input_idx), .w_neuron_idx(w_neuron_idx),
        .w_last_input(w_last_input), .w_last_neuron(w_last_neuron)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return DW'(int'(a) * 40503 + 12345);
    endfunction

    always @(posedge clk)
        if (mem_read_enable)
            mem_read_data <= mem_f(mem_read_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample(input int mode);
        int n, i;
        check("occupancy", 32'(rd_cnt - out_cnt <= 2), 1);
        if (!done)
            check("busy", 32'(busy), 1);
        if (mem_read_enable) begin
            n = rd_cnt / WPN;
            i = rd_cnt % WPN;
            check("rd_count", 32'(rd_cnt < TOTAL), 1);
            check("rd_addr", 32'(mem_read_addr), (run_base + n * WPN + i) & ((1 << AW) - 1));
            rd_cnt++;
        end
        if (mode == 0) begin
            check("rd_stream", 32'(mem_read_enable), 32'(cyc <= TOTAL));
            check("out_stream", 32'(w_valid), 32'(cyc >= 3 && cyc <= TOTAL + 2));
        end else if (cyc <= 2)
            check("first_valid", 32'(w_valid), 0);
        if (prev_v && !prev_r) begin
            check("stall_valid", 32'(w_valid), 1);
            check("stall_data", 32'(w_data), 32'(prev_d));
        end
        if (w_valid && w_ready) begin
            n = out_cnt / WPN;
            i = out_cnt % WPN;
            check("word_count", 32'(out_cnt < TOTAL), 1);
            check("w_data", 32'(w_data), 32'(mem_f(AW'(run_base + n * WPN + i))));
            check("w_input_idx", 32'(w_input_idx), i);
            check("w_neuron_idx", 32'(w_neuron_idx), n);
            check("w_last_input", 32'(w_last_input), 32'(i == WPN - 1));
            check("w_last_neuron", 32'(w_last_neuron), 32'(n == NN - 1));
            out_cnt++;
            last_acc = cyc;
        end
        if (done) begin
            check("done_words", out_cnt, TOTAL);
            check("done_timing", last_acc, cyc - 1);
            check("done_busy", 32'(busy), 0);
            if (mode == 0)
                check("done_cycle", cyc, TOTAL + 3);
        end
        prev_v = w_valid;
        prev_r = w_ready;
        prev_d = w_data;
    endtask

    // mode: 0 ready always, 1 ready 1,0,0,1 pattern, 2 random ready, 3 ready low
    task automatic run(input int base, input int mode, input int abort_at, input bit hold);
        bit fin = 1'b0;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b0;
        base_addr = AW'(base);
        #1;
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        run_base = base;
        rd_cnt = 0;
        out_cnt = 0;
        last_acc = -10;
        prev_v = 1'b0;
        prev_r = 1'b0;
        cyc = 0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = hold;
            base_addr = AW'($urandom);
            abort = cyc == abort_at;
            w_ready = mode == 0 ? 1'b1 :
                      mode == 1 ? ((cyc - 1) % 4 == 0 || (cyc - 1) % 4 == 3) :
                      mode == 2 ? 1'($urandom_range(1)) : 1'b0;
            #1;
            sample(mode);
            fin = done || abort;
        end
        if (!fin)
            check("timeout", 0, 1);
        if (abort_at > 0) begin
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            #1;
            check("abort_busy", 32'(busy), 0);
            check("abort_valid", 32'(w_valid), 0);
            check("abort_read", 32'(mem_read_enable), 0);
            repeat (3) begin
                @(negedge clk);
                #1;
                check("abort_no_done", 32'(done), 0);
                check("abort_idle", 32'(busy), 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        w_ready = 1'b1;
        base_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_en", 32'(mem_read_enable), 0);
        check("rst_rd_addr", 32'(mem_read_addr), 0);
        check("rst_valid", 32'(w_valid), 0);
        check("rst_data", 32'(w_data), 0);
        check("rst_idx", 32'({w_input_idx, w_neuron_idx, w_last_input, w_last_neuron}), 0);
        start = 1'b0;
        rst_n = 1'b1;

        run(32'h010, 0, 0, 1'b0);
        run(32'h010, 1, 0, 1'b0);
        run(32'h3FE, 0, 0, 1'b0);
        run(32'h123, 3, 3, 1'b0);
        run(32'h055, 0, 0, 1'b0);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("start_abort_busy", 32'(busy), 0);
        check("start_abort_read", 32'(mem_read_enable), 0);

        run(32'h200, 2, 0, 1'b1);
        run(32'h201, 2, 0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("hold_released", 32'(busy), 0);

        for (int r = 0; r < 4; r++)
            run(int'($urandom_range(1023)), 2, 0, 1'b0);
        run(int'($urandom_range(1023)), 2, 4 + int'($urandom_range(6)), 1'b0);
        run(32'h000, 1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/weight_fetch_sequencer.md
Name: weight_fetch_sequencer

Overview:
Controller that sequences reads from a layer's weight memory (1-cycle registered read latency) and streams weights to the neuron MAC datapath with a valid/ready handshake. On start, it walks every neuron and every input in order and tags each weight with neuron/input indices and last flags. A 2-entry output buffer absorbs the read latency, so throughput is one weight per cycle with no loss under backpressure.

Parameters:
NUM_INPUTS, 5, weights per neuron (≥1)
NUM_NEURONS, 1, neurons in layer (≥1)
ADDR_WIDTH, 10, weight memory address width
DATA_WIDTH, 16, weight word width
IDX_WIDTH, 8, width of index outputs (≥ clog2 of NUM_INPUTS+1 and NUM_NEURONS)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a layer fetch; sampled only in IDLE
abort  in  1  synchronous cancel of an active fetch
base_addr  in  ADDR_WIDTH  address of neuron 0 input 0; latched on accepted start
busy  out  1  high from the cycle after accepted start until return to IDLE
done  out  1  one-cycle pulse when the final weight has been accepted downstream
mem_read_enable  out  1  read strobe to weight memory
mem_read_addr  out  ADDR_WIDTH  read address
mem_read_data  in  DATA_WIDTH  memory data, valid the cycle after mem_read_enable
w_valid  out  1  output weight valid
w_ready  in  1  downstream accepts when w_valid && w_ready
w_data  out  DATA_WIDTH  weight
w_input_idx  out  IDX_WIDTH  input index 0..NUM_INPUTS-1
w_neuron_idx  out  IDX_WIDTH  neuron index 0..NUM_NEURONS-1
w_last_input  out  1  last word of current neuron
w_last_neuron  out  1  word belongs to final neuron

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; busy, done, mem_read_enable, w_valid = 0; mem_read_addr, w_data, indices, last flags = 0; counters, FIFO and in-flight flag cleared. Reset overrides all other inputs.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 && abort=0 -> latch base_addr, clear counters, go to FETCH. start while busy is ignored.
- FETCH: issue a read (mem_read_enable=1) in any cycle where FIFO occupancy + in-flight + incoming < 2 after accounting for a same-cycle pop (pop = w_valid && w_ready).
- Address = base + n*NUM_INPUTS + i, truncated mod 2^ADDR_WIDTH (wraps silently).
- Input index i increments per issue; at NUM_INPUTS-1 it wraps to 0 and n increments. After issuing the last word (n=NUM_NEURONS-1, i=NUM_INPUTS-1), go to DRAIN.
- Sideband: i, n and the last flags are registered alongside each read and pushed into the FIFO with mem_read_data the following cycle.
- Output: the FIFO head drives w_*. w_data is held stable while w_valid=1 && w_ready=0. No bubbles while issuing and w_ready=1: sustained 1 word/cycle. First w_valid appears 2 cycles after start is accepted.
- DRAIN: no reads; when FIFO empty and nothing in flight -> DONE.
- DONE: done=1 for exactly one cycle, busy=0, next state IDLE. start may be accepted in the cycle following done.
- abort=1 in FETCH/DRAIN: next cycle is IDLE. FIFO and in-flight are flushed, w_valid=0, no done pulse. abort in IDLE has no effect. If start and abort are both high in IDLE, abort wins and start is dropped.
- FIFO full and w_ready=0: no read issued; counters frozen.
- mem_read_enable is never asserted outside FETCH.

Optional Feature:
WFETCH_BIAS_EN: when defined, each neuron fetches NUM_INPUTS+1 words. The extra word, at address base + n*(NUM_INPUTS+1) + NUM_INPUTS, is the bias. It carries w_input_idx=NUM_INPUTS and is the word with w_last_input=1. Neuron stride becomes NUM_INPUTS+1. When not defined, the stride is NUM_INPUTS, there is no bias word, and w_last_input is set on input NUM_INPUTS-1.

Test Plan:
- NUM_INPUTS=5, NUM_NEURONS=2, base=0x010, w_ready=1, start pulse -> reads addresses 0x010..0x019 on consecutive cycles; 10 words out with indices (0,0)..(1,4); w_last_input on words 5 and 10; w_last_neuron on words 6–10; done exactly one cycle after word 10 is accepted.
- Same config, w_ready toggled 1,0,0,1 repeating -> all 10 words delivered in order with no duplicates or drops; w_data stable while stalled; FIFO occupancy never exceeds 2.
- base=0x3FE, ADDR_WIDTH=10, NUM_INPUTS=5, NUM_NEURONS=1 -> addresses 0x3FE, 0x3FF, 0x000, 0x001, 0x002.
- abort asserted 3 cycles after start with w_ready=0 -> IDLE next cycle, w_valid=0, busy=0, no done; a new start then produces a full correct sequence from index (0,0).
- start held high continuously across a run -> only one run while busy; a second run starts the cycle after the done pulse.
- With WFETCH_BIAS_EN, NUM_INPUTS=5, NUM_NEURONS=2, base=0 -> 12 words, addresses 0..11; words 6 and 12 have w_input_idx=5 and w_last_input=1.
